dsp_master_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single wb_master_interface command port (start/address/selection/

---
 rtl/dsp_master_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_dsp_master_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_master_arbiter.sv
// dsp_master_arbiter: round-robin arbiter that shares one wb_master_interface command port among NREQ requesters.
// Optional transfer timeout (with DRAIN state and err pulses) is enabled by defining DSP_ARB_TIMEOUT_EN.
module dsp_master_arbiter #(
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*aw-1:0]  req_adr,
  input  logic [NREQ*4-1:0]   req_sel,
  input  logic [NREQ-1:0]     req_we,
  input  logic [NREQ*dw-1:0]  req_dat,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [NREQ-1:0]     err,
  output logic [dw-1:0]       rd_data,
  output logic                busy,
  output logic                start,
  output logic [aw-1:0]       address,
  output logic [3:0]          selection,
  output logic                write,
  output logic [dw-1:0]       data_wr,
  input  logic                active,
  input  logic [dw-1:0]       data_rd
);
  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("dsp_master_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
  end

`ifdef DSP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, WAIT_ACT = 3'd2, BUSY = 3'd3, DONE = 3'd4, DRAIN = 3'd5
  } state_t;
  logic [CW-1:0]   cnt_r;
  logic            timed_out_r;
  logic [NREQ-1:0] err_r;
  assign err = err_r;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, WAIT_ACT = 3'd2, BUSY = 3'd3, DONE = 3'd4
  } state_t;
  assign err = '0;
`endif

  state_t          state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   win_r;
  logic [PW-1:0]   win_s;
  logic            any_s;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] done_r;
  logic [dw-1:0]   rd_data_r;
  logic            busy_r;
  logic            start_r;
  logic [aw-1:0]   address_r;
  logic [3:0]      selection_r;
  logic            write_r;
  logic [dw-1:0]   data_wr_r;

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign rd_data   = rd_data_r;
  assign busy      = busy_r;
  assign start     = start_r;
  assign address   = address_r;
  assign selection = selection_r;
  assign write     = write_r;
  assign data_wr   = data_wr_r;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Rotating-priority pick: scan downward so the smallest offset from ptr_r wins
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    win_s = '0;
    any_s = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum   = {1'b0, ptr_r} + (PW+1)'(k);
      idx   = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
      win_s = req[idx] ? idx : win_s;
      any_s = any_s | req[idx];
    end
  end

  // Sequencer: latches the winner's command, drives the master handshake and all outputs
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      win_r       <= '0;
      gnt_r       <= '0;
      done_r      <= '0;
      rd_data_r   <= '0;
      busy_r      <= 1'b0;
      start_r     <= 1'b0;
      address_r   <= '0;
      selection_r <= 4'h0;
      write_r     <= 1'b0;
      data_wr_r   <= '0;
`ifdef DSP_ARB_TIMEOUT_EN
      cnt_r       <= '0;
      timed_out_r <= 1'b0;
      err_r       <= '0;
`endif
    end else begin
      gnt_r   <= '0;
      start_r <= 1'b0;
      done_r  <= '0;
`ifdef DSP_ARB_TIMEOUT_EN
      err_r   <= '0;
`endif
      case (state_r)
        IDLE: begin
          if (any_s) begin
            win_r       <= win_s;
            address_r   <= req_adr[win_s*aw +: aw];
            selection_r <= req_sel[win_s*4 +: 4];
            write_r     <= req_we[win_s];
            data_wr_r   <= req_dat[win_s*dw +: dw];
            gnt_r       <= onehot(win_s);
            busy_r      <= 1'b1;
            state_r     <= START;
          end
        end
        START: begin
          start_r <= 1'b1;
          state_r <= WAIT_ACT;
`ifdef DSP_ARB_TIMEOUT_EN
          cnt_r       <= '0;
          timed_out_r <= 1'b0;
`endif
        end
        WAIT_ACT: begin
`ifdef DSP_ARB_TIMEOUT_EN
          if (cnt_r == CW'(TIMEOUT - 1)) begin
            done_r      <= onehot(win_r);
            err_r       <= onehot(win_r);
            timed_out_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
            if (active) state_r <= BUSY;
          end
`else
          if (active) state_r <= BUSY;
`endif
        end
        BUSY: begin
          if (!active) begin
            rd_data_r <= data_rd;
            done_r    <= onehot(win_r);
            state_r   <= DONE;
          end
`ifdef DSP_ARB_TIMEOUT_EN
          // A real completion in the same cycle as expiry takes precedence
          else if (cnt_r == CW'(TIMEOUT - 1)) begin
            done_r      <= onehot(win_r);
            err_r       <= onehot(win_r);
            timed_out_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
`endif
        end
        DONE: begin
          ptr_r <= (win_r == PW'(NREQ - 1)) ? '0 : win_r + PW'(1);
`ifdef DSP_ARB_TIMEOUT_EN
          if (timed_out_r) begin
            state_r <= DRAIN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          // No new start while the abandoned master transfer is still running
          if (!active) begin
            busy_r      <= 1'b0;
            timed_out_r <= 1'b0;
            state_r     <= IDLE;
          end
`else
          busy_r  <= 1'b0;
          state_r <= IDLE;
`endif
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_master_arbiter.sv
// tb_dsp_master_arbiter: randomized self-checking bench for dsp_master_arbiter (default build).
// A transaction-level model predicts winners, latched commands, pulse timing and read data.
module tb_dsp_master_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_adr;
  logic [NREQ*4-1:0] req_sel;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*DW-1:0] req_dat;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic [DW-1:0]     rd_data;
  logic              busy;
  logic              start;
  logic [AW-1:0]     address;
  logic [3:0]        selection;
  logic              write;
  logic [DW-1:0]     data_wr;
  logic              active;
  logic [DW-1:0]     data_rd;

  logic [AW-1:0] adr_v [NREQ];
  logic [3:0]    sel_v [NREQ];
  logic [DW-1:0] dat_v [NREQ];

  int            errors = 0;
  int            checks = 0;
  int            ptr_m;
  logic [DW-1:0] rd_m;

  always #5 wb_clk = ~wb_clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_adr[g*AW +: AW] = adr_v[g];
    assign req_sel[g*4 +: 4]   = sel_v[g];
    assign req_dat[g*DW +: DW] = dat_v[g];
  end

  dsp_master_arbiter #(.aw(AW), .dw(DW), .NREQ(NREQ), .TIMEOUT(1024)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .req(req), .req_adr(req_adr), .req_sel(req_sel),
    .req_we(req_we), .req_dat(req_dat), .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
    .busy(busy), .start(start), .address(address), .selection(selection), .write(write),
    .data_wr(data_wr), .active(active), .data_rd(data_rd)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] bit_of(input int w);
    logic [NREQ-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic rand_slice(input int i);
    adr_v[i]  = $urandom;
    sel_v[i]  = 4'($urandom);
    req_we[i] = 1'($urandom);
    dat_v[i]  = $urandom;
  endtask

  // Called at a negedge whose following posedge finds the arbiter idle with req already driven.
  task automatic run_xfer(input bit drop, input int lat1, input int lat2, input logic [DW-1:0] rdv);
    int w;
    bit bad;
    logic [AW-1:0] e_adr;
    logic [3:0]    e_sel;
    logic          e_we;
    logic [DW-1:0] e_dat;
    w     = pick(req, ptr_m);
    e_adr = adr_v[w];
    e_sel = sel_v[w];
    e_we  = req_we[w];
    e_dat = dat_v[w];
    bad   = 1'b0;
    @(negedge wb_clk);
    check_eq("gnt", gnt, bit_of(w));
    check_eq("address", address, e_adr);
    check_eq("selection", selection, e_sel);
    check_eq("write", write, e_we);
    check_eq("data_wr", data_wr, e_dat);
    check_eq("busy_at_gnt", busy, 1'b1);
    check_eq("start_early", start, 1'b0);
    check_eq("rd_data_held", rd_data, rd_m);
    rand_slice(w);
    @(negedge wb_clk);
    check_eq("start", start, 1'b1);
    check_eq("gnt_pulse", gnt, '0);
    repeat (lat1) begin
      @(negedge wb_clk);
      bad |= start || (gnt != '0) || (done != '0) || !busy || (address !== e_adr)
             || (selection !== e_sel) || (write !== e_we) || (data_wr !== e_dat);
    end
    active = 1'b1;
    repeat (lat2) begin
      @(negedge wb_clk);
      bad |= start || (gnt != '0) || (done != '0) || !busy || (address !== e_adr)
             || (selection !== e_sel) || (write !== e_we) || (data_wr !== e_dat);
    end
    active  = 1'b0;
    data_rd = rdv;
    @(negedge wb_clk);
    check_eq("done", done, bit_of(w));
    check_eq("rd_data", rd_data, rdv);
    check_eq("busy_at_done", busy, 1'b1);
    check_eq("err", err, '0);
    bad |= start || (gnt != '0) || (data_wr !== e_dat) || (address !== e_adr);
    rd_m  = rdv;
    ptr_m = (w + 1) % NREQ;
    data_rd = $urandom;
    @(negedge wb_clk);
    bad |= busy || (done != '0) || (gnt != '0) || start;
    check_eq("hold_and_idle", bad, 1'b0);
    if (drop) req[w] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int w;
    wb_rst  = 1'b1;
    req     = '0;
    req_we  = '0;
    active  = 1'b0;
    data_rd = '0;
    for (int i = 0; i < NREQ; i++) begin
      adr_v[i] = '0;
      sel_v[i] = 4'h0;
      dat_v[i] = '0;
    end
    ptr_m = 0;
    rd_m  = '0;
    repeat (3) @(negedge wb_clk);
    check_eq("rst_gnt", gnt, '0);
    check_eq("rst_done", done, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_start", start, 1'b0);
    check_eq("rst_address", address, '0);
    check_eq("rst_rd_data", rd_data, '0);
    wb_rst = 1'b0;

    // Single read from requester 1
    req[1] = 1'b1;
    adr_v[1] = 32'h0000_0010;
    sel_v[1] = 4'hF;
    req_we[1] = 1'b0;
    run_xfer(1'b1, 1, 2, 32'hDEAD_BEEF);

    // Pointer now 2: requests on 0 and 1 wrap round to 0 first, then 1
    req = 4'b0011;
    run_xfer(1'b1, 0, 1, 32'h0000_0A0A);
    run_xfer(1'b1, 2, 3, 32'h0000_0B0B);

    // Write from requester 3; its slice changes right after the grant
    req = 4'b1000;
    adr_v[3] = 32'h0000_0020;
    sel_v[3] = 4'hF;
    req_we[3] = 1'b1;
    dat_v[3] = 32'h1234_5678;
    run_xfer(1'b1, 1, 4, 32'h5555_AAAA);

    // All four held high: rotating order 0,1,2,3,0
    req = 4'b1111;
    for (int n = 0; n < 5; n++) run_xfer(1'b0, n % 3, 1 + n % 2, $urandom);
    req = '0;

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NREQ; i++) rand_slice(i);
      req = req | NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
      run_xfer($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(1, 4), $urandom);
    end

    // Reset while the transfer is in BUSY
    req = 4'b0100;
    w = pick(req, ptr_m);
    @(negedge wb_clk);
    check_eq("t5_gnt", gnt, bit_of(w));
    @(negedge wb_clk);
    check_eq("t5_start", start, 1'b1);
    active = 1'b1;
    repeat (2) @(negedge wb_clk);
    check_eq("t5_busy_before", busy, 1'b1);
    wb_rst = 1'b1;
    req    = '0;
    @(negedge wb_clk);
    bad = (gnt != '0) || (done != '0) || busy || start || (address != '0) || (selection != 4'h0)
          || write || (data_wr != '0) || (rd_data != '0) || (err != '0);
    check_eq("t5_outputs_cleared", bad, 1'b0);
    active = 1'b0;
    wb_rst = 1'b0;
    ptr_m  = 0;
    rd_m   = '0;
    bad    = 1'b0;
    repeat (3) begin
      @(negedge wb_clk);
      bad |= (done != '0) || busy || start || (gnt != '0);
    end
    check_eq("t5_no_done_after_reset", bad, 1'b0);
    req = 4'b1111;
    run_xfer(1'b1, 1, 1, 32'hCAFE_F00D);
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
